irq_pending_arbiter: RTL
========================

# irq_pending_arbiter

Captures eight interrupt/request lines into a pending register and presents the highest-priority unmasked pending line as a 3-bit index over a valid/ready handshake. It sits directly downstream of the raw request sources and uses the same 8-to-3 priority order as the team's priority encoder: bit 7 is highest, bit 0 is lowest. It adds the state that encoder lacks: event capture, masking, a stable handshake, clear-on-accept and overrun detection.

## Interface
Parameters:
- EDGE, default 1: 1 = rising-edge capture of req_in; 0 = level capture.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_in  in  8  request lines; synchronous to clk.
- mask  in  8  1 = line ineligible for selection; capture is unaffected.
- irq_ready  in  1  consumer accepts the presented index.
- overrun_clr  in  1  single-cycle pulse; clears all overrun bits.
- irq_valid  out  1  an index is presented.
- irq_id  out  3  index of the presented line.
- pending  out  8  current pending register.
- overrun  out  8  sticky per-line overrun flags.

## Operation
- req_q: 8-bit register of req_in. Reset value is 0, so a line already high when reset is released counts as an edge.
- set vector: req_in & ~req_q when EDGE=1; req_in when EDGE=0.
- clr vector: one-hot(irq_id) when irq_valid & irq_ready; otherwise 0.
- pending next = (pending & ~clr) | set. If set and clr hit the same bit in the same cycle, set wins and the bit stays pending.
- eligible = pending & ~mask. Selection takes the highest set index.
- FSM with two states:
  - IDLE: irq_valid=0. If eligible != 0, load irq_id = highest eligible index and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: irq_valid=1. irq_id is frozen; there is no preemption by a higher-priority arrival, a mask change, or a new set on any line. When irq_ready=1, clear that pending bit and go to IDLE. Otherwise stay in PRESENT.
- Overrun (EDGE=1 only):
  - overrun[i] is set when set[i]=1, pending[i]=1 and clr[i]=0.
  - overrun_clr clears all bits. If overrun_clr and a new overrun occur in the same cycle, the set wins.
  - With EDGE=0, overrun is held at 0.
- Masked pending bits stay pending indefinitely. They become presentable once unmasked.
- If mask[irq_id] rises while in PRESENT, the presentation still completes.

## Timing
- Reset (asynchronous, immediate) drives: req_q=0, pending=0, overrun=0, irq_valid=0, irq_id=0, FSM=IDLE. A reset mid-handshake drops irq_valid at once; the accept is lost and no pending bit is cleared.
- Latency from req_in high (sampled at edge k) to the pending bit set is edge k.
- Latency from req_in high to irq_valid=1 is after edge k+1, i.e. 2 clocks.
- Accept happens at a rising edge where irq_valid=1 and irq_ready=1. irq_valid is 0 for exactly one cycle after each accept (the IDLE bubble). The next index appears at the following edge if eligible != 0, giving a maximum throughput of 1 index per 2 clocks.
- irq_ready while irq_valid=0 is ignored.
- irq_id holds its last value in IDLE and is valid only while irq_valid=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then single edge:
  - Stimulus: EDGE=1, mask=0, pulse req_in[3] for one cycle, irq_ready=1.
  - Response: irq_valid rises 2 clocks after the sample with irq_id=3; accepted the next edge; pending[3]=0; irq_valid=0 for one cycle, then stays 0.
- Priority order:
  - Stimulus: edges on bits 1, 5, 6 in the same cycle, irq_ready=1.
  - Response: irq_id sequence is 6, 5, 1 with one bubble between each; pending ends at 0.
- Hold and no preemption:
  - Stimulus: present id 2 with irq_ready=0; assert an edge on bit 7 and set mask[2]=1 while stalled.
  - Response: irq_id stays 2 until ready, then 7 is presented.
- Overrun and set-wins:
  - Stimulus: stall bit 4 pending with a second edge on bit 4.
  - Response: overrun=8'h10.
  - Stimulus: an edge on bit 4 in the same cycle as its accept.
  - Response: pending[4] stays 1 and no overrun is raised.
  - Stimulus: overrun_clr.
  - Response: overrun=0.
- Mask, level mode and reset:
  - Stimulus: EDGE=0, req_in[0] held high, mask[0]=1.
  - Response: pending[0]=1, irq_valid stays 0.
  - Stimulus: unmask bit 0.
  - Response: id 0 is presented and re-presented after each accept while req_in[0] stays high.
  - Stimulus: assert rst_n low mid-PRESENT.
  - Response: irq_valid, pending and overrun go to 0 immediately.

Source files
------------

// File: rtl/irq_pending_arbiter.sv
// Captures eight request lines into a pending register and presents the
// highest-priority unmasked line (bit 7 highest) over a valid/ready handshake.
module irq_pending_arbiter #(
    parameter int EDGE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       irq_ready,
    input  logic       overrun_clr,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] pending,
    output logic [7:0] overrun
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] req_q_reg;
    logic [7:0] pending_reg, pending_next;
    logic [7:0] overrun_reg, overrun_next;
    logic [2:0] irq_id_reg, irq_id_next;
    logic [7:0] set_vec, clr_vec, eligible;
    logic [2:0] top_idx;
    logic       accept;

    assign accept   = (state_reg == PRESENT) && irq_ready;
    assign eligible = pending_reg & ~mask;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            assign set_vec[gi] = (EDGE != 0) ? (req_in[gi] & ~req_q_reg[gi]) : req_in[gi];
            assign clr_vec[gi] = accept && (irq_id_reg == 3'(gi));
            // A new event in the accept cycle wins over the clear.
            assign pending_next[gi] = (pending_reg[gi] & ~clr_vec[gi]) | set_vec[gi];
            if (EDGE != 0) begin : g_ovr
                assign overrun_next[gi] = (overrun_reg[gi] & ~overrun_clr)
                                        | (set_vec[gi] & pending_reg[gi] & ~clr_vec[gi]);
            end else begin : g_no_ovr
                assign overrun_next[gi] = 1'b0;
            end
        end
    endgenerate

    // Ascending scan: the last hit is the highest eligible index.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        irq_id_next = irq_id_reg;
        case (state_reg)
            IDLE: begin
                if (eligible != 8'd0) begin
                    irq_id_next = top_idx;
                    state_next  = PRESENT;
                end
            end
            PRESENT: begin
                // Index is frozen until accepted; no preemption.
                if (irq_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            req_q_reg   <= 8'd0;
            pending_reg <= 8'd0;
            overrun_reg <= 8'd0;
            irq_id_reg  <= 3'd0;
        end else begin
            state_reg   <= state_next;
            req_q_reg   <= req_in;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            irq_id_reg  <= irq_id_next;
        end
    end

    assign irq_valid = (state_reg == PRESENT);
    assign irq_id    = irq_id_reg;
    assign pending   = pending_reg;
    assign overrun   = overrun_reg;

endmodule
